// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan controller.
// Scan states are plain constants so older tools and netlists see fixed encodings.
package seg7_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_OFF   = 2'd0;
    localparam state_t ST_BLANK = 2'd1;
    localparam state_t ST_SHOW  = 2'd2;

    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [7:0] ANODE_OFF  = 8'hFF;
    localparam int         MAX_DIGITS = 8;

    // Callers zero-extend their packed BCD word to the widest supported display.
    function automatic logic [3:0] bcd_digit(input logic [4*MAX_DIGITS-1:0] v,
                                             input logic [2:0] i);
        return v[{i, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Control, value handshake and pin-side signals of the scan controller.
// The master side belongs to whoever drives the controller; the slave side is the controller.
interface seg7_scan_ctrl_if #(parameter int NUM_DIGITS = 4);

    logic                    en;
    logic                    lz_en;
    logic [4*NUM_DIGITS-1:0] value_in;
    logic                    value_valid;
    logic                    value_ready;
    logic [6:0]              num;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_tick;

    modport master (
        output en, lz_en, value_in, value_valid,
        input  value_ready, num, an, frame_tick
    );

    modport slave (
        input  en, lz_en, value_in, value_valid,
        output value_ready, num, an, frame_tick
    );

endinterface

// File: rtl/seg7_scan_ctrl_prescaler.sv
// Dwell counter: counts 0..SCAN_DIV-1 and flags the last blanking cycle and the last dwell cycle.
module scan_prescaler #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tc_o,
    output logic blank_end_o
);

    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc_o        = (cnt_q == CW'(SCAN_DIV - 1));
    assign blank_end_o = (cnt_q == CW'(BLANK_CYCLES - 1));

    always_comb begin
        if (clr_i || tc_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Scans NUM_DIGITS common-anode digits through one shared BCD decoder, taking new values
// through a one-deep pending buffer that is only committed at frame boundaries.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_ctrl_if.slave   bus
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;
    localparam int VW = 4 * MAX_DIGITS;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         shadow_q, shadow_d;
    logic [DW-1:0]         pend_q, pend_d;
    logic                  pendFull_q, pendFull_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            num_q, num_d;
    logic                  tick_q, tick_d;

    logic                  prescaleClr;
    logic                  dwellEnd;
    logic                  blankEnd;
    logic                  commit;
    logic                  transfer;
    logic [VW-1:0]         shadowWide;
    logic [3:0]            digit;
    logic                  nonzeroAbove;
    logic                  suppressed;

    assign prescaleClr = (state_q == ST_OFF) || !bus.en;

    scan_prescaler #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_prescaler (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (prescaleClr),
        .tc_o        (dwellEnd),
        .blank_end_o (blankEnd)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tick_d  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            ST_OFF: begin
                idx_d  = '0;
                commit = pendFull_q;
                if (bus.en) begin
                    state_d = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (blankEnd) begin
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (dwellEnd) begin
                    state_d = ST_BLANK;
                    if (idx_q == IW'(NUM_DIGITS - 1)) begin
                        idx_d  = '0;
                        tick_d = 1'b1;
                        commit = pendFull_q;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_OFF;
        endcase
        // Disabling mid-scan abandons the frame; a value waiting in OFF still commits there.
        if (!bus.en && state_q != ST_OFF) begin
            state_d = ST_OFF;
            idx_d   = '0;
            tick_d  = 1'b0;
            commit  = 1'b0;
        end
        transfer   = bus.value_valid && !pendFull_q;
        pendFull_d = (pendFull_q && !commit) || transfer;
        pend_d     = transfer ? bus.value_in : pend_q;
        shadow_d   = commit ? pend_q : shadow_q;
    end

    // Pin values are decoded from next-state values so they change on the same edge as the FSM.
    always_comb begin
        shadowWide   = VW'(shadow_d);
        digit        = bcd_digit(shadowWide, 3'(idx_d));
        nonzeroAbove = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(idx_d) && bcd_digit(shadowWide, 3'(j)) != 4'd0) begin
                nonzeroAbove = 1'b1;
            end
        end
        suppressed = bus.lz_en && (idx_d != '0) && !nonzeroAbove;
        an_d       = ANODE_OFF[NUM_DIGITS-1:0];
        num_d      = '0;
        if (state_d == ST_SHOW && !suppressed && digit <= BCD_MAX) begin
            an_d[idx_d] = 1'b0;
            num_d       = {3'b000, digit};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_OFF;
            idx_q      <= '0;
            shadow_q   <= '0;
            pend_q     <= '0;
            pendFull_q <= 1'b0;
            an_q       <= ANODE_OFF[NUM_DIGITS-1:0];
            num_q      <= '0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            pend_q     <= pend_d;
            pendFull_q <= pendFull_d;
            an_q       <= an_d;
            num_q      <= num_d;
            tick_q     <= tick_d;
        end
    end

    assign bus.value_ready = !pendFull_q;
    assign bus.an          = an_q;
    assign bus.num         = num_q;
    assign bus.frame_tick  = tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl with 4 digits, 4-cycle dwell and 1-cycle blanking.
module tb_seg7_scan_ctrl;

    localparam int ND = 4;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] num;
        logic       tick;
    } exp_t;

    typedef struct {
        logic [15:0]     value;
        logic            lz;
        logic [3:0][3:0] an;
        logic [3:0][6:0] num;
    } vec_t;

    localparam logic [3:0][3:0] AN_ALL  = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    localparam logic [3:0][6:0] NUM_0   = {7'd0, 7'd0, 7'd0, 7'd0};
    localparam logic [3:0][6:0] NUM_1234 = {7'd1, 7'd2, 7'd3, 7'd4};
    localparam logic [3:0][6:0] NUM_5678 = {7'd5, 7'd6, 7'd7, 7'd8};
    localparam logic [3:0][6:0] NUM_9999 = {7'd9, 7'd9, 7'd9, 7'd9};

    logic clk = 1'b0;
    logic rst;
    exp_t expQ[$];
    vec_t vecs[7];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seg7_scan_ctrl_if #(.NUM_DIGITS(ND)) bus();

    seg7_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic enV, input logic lzV, input logic validV,
                                 input logic [15:0] valueV);
        bus.en          = enV;
        bus.lz_en       = lzV;
        bus.value_valid = validV;
        bus.value_in    = valueV;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pushRec(input logic [3:0] an, input logic [6:0] num, input logic tick);
        expQ.push_back('{an: an, num: num, tick: tick});
    endtask

    // One frame is four dwells of {one blank cycle, three show cycles}.
    task automatic pushFrame(input logic [3:0][3:0] an, input logic [3:0][6:0] num,
                             input logic firstTick, input int count);
        for (int k = 0; k < count; k++) begin
            if (k % 4 == 0) begin
                pushRec(4'hF, 7'd0, (k == 0) ? firstTick : 1'b0);
            end else begin
                pushRec(an[k / 4], num[k / 4], 1'b0);
            end
        end
    endtask

    task automatic sampleCycle(input string tag, input int i);
        exp_t e;
        step();
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s[%0d] scoreboard empty: got output with no expectation", tag, i);
        end else begin
            e = expQ.pop_front();
            checkOutput($sformatf("%s[%0d] an", tag, i), 32'(bus.an), 32'(e.an));
            checkOutput($sformatf("%s[%0d] num", tag, i), 32'(bus.num), 32'(e.num));
            checkOutput($sformatf("%s[%0d] tick", tag, i), 32'(bus.frame_tick), 32'(e.tick));
        end
    endtask

    // Hands a value over while the display is off; it commits on the following OFF cycle.
    task automatic loadOff(input logic [15:0] value, input logic lz);
        applyStimulus(1'b0, lz, 1'b1, value);
        checkOutput("load ready idle", 32'(bus.value_ready), 32'd1);
        step();
        applyStimulus(1'b0, lz, 1'b0, value);
        checkOutput("load ready full", 32'(bus.value_ready), 32'd0);
        step();
        checkOutput("load ready commit", 32'(bus.value_ready), 32'd1);
    endtask

    task automatic stopScan(input string tag);
        bus.en = 1'b0;
        step();
        checkOutput({tag, " off an"}, 32'(bus.an), 32'hF);
        checkOutput({tag, " off num"}, 32'(bus.num), 32'd0);
    endtask

    initial begin
        int   gap;
        logic seen;

        vecs[0] = '{16'h1234, 1'b0, AN_ALL, NUM_1234};
        vecs[1] = '{16'h0040, 1'b1, {4'b1111, 4'b1111, 4'b1101, 4'b1110}, {7'd0, 7'd0, 7'd4, 7'd0}};
        vecs[2] = '{16'h0000, 1'b1, {4'b1111, 4'b1111, 4'b1111, 4'b1110}, NUM_0};
        vecs[3] = '{16'h00A1, 1'b0, {4'b0111, 4'b1011, 4'b1111, 4'b1110}, {7'd0, 7'd0, 7'd0, 7'd1}};
        vecs[4] = '{16'h0000, 1'b0, AN_ALL, NUM_0};
        vecs[5] = '{16'h9087, 1'b1, AN_ALL, {7'd9, 7'd0, 7'd8, 7'd7}};
        vecs[6] = '{16'h0F05, 1'b1, {4'b1111, 4'b1111, 4'b1101, 4'b1110}, {7'd0, 7'd0, 7'd0, 7'd5}};

        // Reset held for two cycles with scanning already requested.
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
        for (int r = 0; r < 2; r++) begin
            step();
            checkOutput($sformatf("reset%0d an", r), 32'(bus.an), 32'hF);
            checkOutput($sformatf("reset%0d num", r), 32'(bus.num), 32'd0);
            checkOutput($sformatf("reset%0d ready", r), 32'(bus.value_ready), 32'd1);
            checkOutput($sformatf("reset%0d tick", r), 32'(bus.frame_tick), 32'd0);
        end
        rst = 1'b0;
        pushFrame(AN_ALL, NUM_0, 1'b0, 16);
        pushRec(4'hF, 7'd0, 1'b1);
        for (int i = 0; i < 17; i++) sampleCycle("boot", i);

        gap  = 0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            step();
            gap++;
            if (bus.frame_tick) seen = 1'b1;
        end
        checkOutput("frame period", 32'(gap), 32'd16);
        stopScan("boot");

        for (int v = 0; v < 7; v++) begin
            loadOff(vecs[v].value, vecs[v].lz);
            applyStimulus(1'b1, vecs[v].lz, 1'b0, vecs[v].value);
            pushFrame(vecs[v].an, vecs[v].num, 1'b0, 16);
            pushRec(4'hF, 7'd0, 1'b1);
            for (int i = 0; i < 17; i++) sampleCycle($sformatf("vec%0d", v), i);
            stopScan($sformatf("vec%0d", v));
        end

        // New value mid-frame shows only after the wrap; a second offer waits for ready.
        loadOff(16'h1234, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h1234);
        pushFrame(AN_ALL, NUM_1234, 1'b0, 16);
        pushFrame(AN_ALL, NUM_5678, 1'b1, 16);
        pushFrame(AN_ALL, NUM_9999, 1'b1, 16);
        pushRec(4'hF, 7'd0, 1'b1);
        for (int i = 0; i < 49; i++) begin
            sampleCycle("update", i);
            if (i == 5) begin
                checkOutput("update ready before offer", 32'(bus.value_ready), 32'd1);
                applyStimulus(1'b1, 1'b0, 1'b1, 16'h5678);
            end
            if (i == 6) begin
                checkOutput("update ready after accept", 32'(bus.value_ready), 32'd0);
                applyStimulus(1'b1, 1'b0, 1'b1, 16'h9999);
            end
            if (i == 15) checkOutput("update ready end of frame", 32'(bus.value_ready), 32'd0);
            if (i == 16) checkOutput("update ready at tick", 32'(bus.value_ready), 32'd1);
            if (i == 17) begin
                checkOutput("update second accepted", 32'(bus.value_ready), 32'd0);
                applyStimulus(1'b1, 1'b0, 1'b0, 16'h9999);
            end
            if (i == 31) checkOutput("update second pending", 32'(bus.value_ready), 32'd0);
            if (i == 32) checkOutput("update second committed", 32'(bus.value_ready), 32'd1);
        end
        stopScan("update");

        // One-cycle enable drop during digit 1 restarts the frame from digit 0.
        loadOff(16'h1234, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h1234);
        pushFrame(AN_ALL, NUM_1234, 1'b0, 7);
        pushRec(4'hF, 7'd0, 1'b0);
        pushFrame(AN_ALL, NUM_1234, 1'b0, 16);
        pushRec(4'hF, 7'd0, 1'b1);
        for (int i = 0; i < 25; i++) begin
            sampleCycle("endrop", i);
            if (i == 6) bus.en = 1'b0;
            if (i == 7) bus.en = 1'b1;
        end
        stopScan("endrop");

        // Reset mid-show clears the display and throws away the pending value.
        loadOff(16'h1234, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h1234);
        pushFrame(AN_ALL, NUM_1234, 1'b0, 6);
        pushRec(4'hF, 7'd0, 1'b0);
        pushFrame(AN_ALL, NUM_0, 1'b0, 16);
        pushFrame(AN_ALL, NUM_0, 1'b1, 16);
        pushRec(4'hF, 7'd0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            sampleCycle("midrst", i);
            if (i == 2) applyStimulus(1'b1, 1'b0, 1'b1, 16'h5678);
            if (i == 3) begin
                checkOutput("midrst pending held", 32'(bus.value_ready), 32'd0);
                applyStimulus(1'b1, 1'b0, 1'b0, 16'h5678);
            end
            if (i == 5) rst = 1'b1;
            if (i == 6) begin
                checkOutput("midrst pending dropped", 32'(bus.value_ready), 32'd1);
                rst = 1'b0;
            end
        end
        stopScan("midrst");

        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller that shares one 7-segment BCD decoder across NUM_DIGITS common-anode digits. It holds a committed display value and steps a digit index with a prescaler. For each dwell it drives the selected BCD digit to the decoder input and asserts one active-low anode. It sits between the counter datapath, which produces packed BCD, and the board's 7-segment pins. New values are accepted through a valid/ready handshake and committed only at frame boundaries, so the display never tears.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8); digit 0 is least significant.
SCAN_DIV, 50000, clock cycles per digit dwell (must be greater than BLANK_CYCLES).
BLANK_CYCLES, 500, cycles at the start of each dwell with all anodes off (ghosting guard; at least 1).

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
en  in  1  scan enable; 0 turns the display off
lz_en  in  1  leading-zero suppression enable
value_in  in  4*NUM_DIGITS  packed BCD; digit i is at bits [4i+3:4i]
value_valid  in  1  value_in is offered
value_ready  out  1  pending buffer is empty; a transfer occurs when valid and ready are both high
num  out  7  decoder input: {3'b000, current digit}, or 0 when not showing
an  out  NUM_DIGITS  anode enables, active low
frame_tick  out  1  one-cycle pulse when a full frame completes

Behaviour:
- Reset values: an all ones, num=0, value_ready=1, frame_tick=0, shadow=0, pending empty, idx=0, cnt=0, state=OFF.
- Registers:
  - shadow: the displayed value.
  - pending: buffer plus full flag.
  - cnt: dwell counter, range 0..SCAN_DIV-1.
  - idx: digit index, range 0..NUM_DIGITS-1.
- States: OFF, BLANK, SHOW.
- OFF:
  - an all ones, num=0, cnt=0, idx=0.
  - If pending is full, commit it on this cycle.
  - If en=1, go to BLANK next cycle.
- BLANK:
  - an all ones, num=0, cnt increments.
  - When cnt==BLANK_CYCLES-1, go to SHOW.
- SHOW:
  - an[idx]=0 and num={3'b0, shadow digit idx}, unless that digit is suppressed.
  - When cnt==SCAN_DIV-1: set cnt=0, go to BLANK, advance idx.
  - If idx==NUM_DIGITS-1, wrap idx to 0, pulse frame_tick for 1 cycle, and commit pending to shadow if full.
- en=0 in any state: go to OFF on the next edge; anodes are off on that same edge.
- an, num and frame_tick are registers updated on the same edge as the state, so there are no combinational glitches on the pins.
- Handshake:
  - value_ready = !pending_full.
  - On a transfer, pending takes value_in and full is set.
  - A commit clears full, so value_ready rises the cycle after the commit.
  - Valid arriving on a commit cycle while pending is empty is accepted normally. It displays at the next commit.
  - Valid held while ready=0 is ignored; the source must hold it.
- Leading-zero suppression: digit i (i≥1) is blanked when lz_en=1 and every shadow digit from NUM_DIGITS-1 down to i is 0. Digit 0 is never suppressed.
- Invalid BCD: a digit value of 10..15 blanks that position (anode off, num=0). The dwell timing is unchanged.
- Timing: dwell is exactly SCAN_DIV cycles; frame period is NUM_DIGITS*SCAN_DIV cycles.
- Reset mid-operation: on the next edge all registers return to reset values, including the pending buffer, which is discarded.

Decomposition:
- Package seg7_pkg holds:
  - state enum (OFF, BLANK, SHOW)
  - BCD_MAX=9
  - ANODE_OFF (all ones)
  - function for digit slicing by index
- Sub-module scan_prescaler: the dwell counter with a terminal-count strobe and a blank-end strobe, parameterized by SCAN_DIV and BLANK_CYCLES.

Test Plan:
All scenarios use NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1.
1. rst=1 for 2 cycles, then en=1 -> during reset an=4'b1111, num=0, value_ready=1. After release:
   - first dwell: 1 cycle with an=1111, then 3 cycles with an=4'b1110 and num=0
   - frame_tick every 16 cycles
2. Send 16'h1234, en=1 -> after the commit, each SHOW window gives:
   - an=1110 with num=4
   - an=1101 with num=3
   - an=1011 with num=2
   - an=0111 with num=1
3. While 1234 is displayed, send 16'h5678 mid-frame, then attempt a second value -> value_ready=0 until the frame_tick cycle. The display stays 1234 until the wrap and then shows 5678; the second value is not accepted until ready returns to 1.
4. lz_en=1, value 16'h0040 -> digits 3 and 2 stay blank (an bits stay 1), digit 1 shows 4, digit 0 shows 0. With value 16'h0000, only digit 0 shows 0.
5. Value 16'h00A1 -> digit 1 is blank with num=0 during its dwell; the other digits are normal and the frame stays 16 cycles.
6. Drop en for 1 cycle mid-SHOW, and separately assert rst mid-SHOW:
   - en drop: an=1111 on the next edge, then a restart at idx=0 with the full blank dwell
   - rst: all outputs return to reset values and the pending value is discarded
